// File: rtl/jtdd2_sndcmd.sv
// Main-CPU to sound-CPU command channel: a small byte FIFO feeding a latch/irq handshake.
// Optional irq re-pulse on missing acknowledge: define JTDD2_SNDCMD_RETRY_EN.
module jtdd2_sndcmd #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned IRQ_LEN   = 16,
    parameter int unsigned RETRY_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_wr,
    input  logic [7:0] main_din,
    input  logic       status_rd,
    output logic [7:0] main_status,
    input  logic       snd_rd,
    output logic [7:0] snd_latch,
    output logic       snd_irq
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StPulse, StWaitAck} state_e;

    state_e          r_state;
    state_e          w_state_d;

    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [7:0]      r_latch;
    logic            r_irq;
    logic [7:0]      r_irq_cnt;
    logic            r_snd_rd_q;

    logic            w_full;
    logic            w_empty;
    logic            w_ack;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_irq_load;
    logic            w_irq_drop;
    logic            w_busy;
    logic            w_retry_fire;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_ack   = snd_rd & ~r_snd_rd_q;
    // A write to a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_push  = main_wr & (~w_full | w_pop);
    assign w_drop  = main_wr & ~w_push;

`ifdef JTDD2_SNDCMD_RETRY_EN
    localparam int unsigned RW = $clog2(RETRY_CYC + 1);

    logic [RW-1:0]   r_retry;

    assign w_retry_fire = (r_retry == RW'(RETRY_CYC - 1));

    // Held at zero outside WAIT_ACK, so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst || r_state != StWaitAck) begin
            r_retry <= '0;
        end else begin
            r_retry <= r_retry + RW'(1);
        end
    end
`else
    // RETRY_CYC has no effect in this build.
    assign w_retry_fire = (RETRY_CYC == 32'd0) & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (!w_empty) w_state_d = StPulse;
            end
            StPulse: begin
                if (w_ack)                  w_state_d = StIdle;
                else if (r_irq_cnt == 8'd1) w_state_d = StWaitAck;
            end
            StWaitAck: begin
                if (w_ack)             w_state_d = StIdle;
                else if (w_retry_fire) w_state_d = StPulse;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != StIdle);
        w_pop      = (r_state == StIdle) & ~w_empty;
        w_irq_load = w_pop | ((r_state == StWaitAck) & ~w_ack & w_retry_fire);
        w_irq_drop = (r_state == StPulse) & (w_ack | (r_irq_cnt == 8'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= main_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_latch    <= 8'h00;
            r_irq      <= 1'b0;
            r_irq_cnt  <= 8'd0;
            r_snd_rd_q <= 1'b0;
        end else begin
            r_snd_rd_q <= snd_rd;

            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_latch  <= r_mem[r_rd_ptr];
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A dropped write wins over a coincident status read.
            if (w_drop)         r_ovf <= 1'b1;
            else if (status_rd) r_ovf <= 1'b0;

            if (w_irq_load) begin
                r_irq     <= 1'b1;
                r_irq_cnt <= 8'(IRQ_LEN);
            end else if (w_irq_drop) begin
                r_irq <= 1'b0;
            end else if (r_state == StPulse) begin
                r_irq_cnt <= r_irq_cnt - 8'd1;
            end
        end
    end

    assign main_status = {w_busy, w_full, r_ovf, 1'b0, 4'(r_count)};
    assign snd_latch   = r_latch;
    assign snd_irq     = r_irq;

endmodule

// File: tb/tb_jtdd2_sndcmd.sv
// Self-checking bench for jtdd2_sndcmd: directed test-plan steps plus random traffic,
// all compared against a queue-based model of the command channel.
module tb_jtdd2_sndcmd;

    localparam int DEPTH     = 4;
    localparam int IRQ_LEN   = 16;
    localparam int RETRY_CYC = 100;
`ifdef JTDD2_SNDCMD_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       main_wr = 1'b0;
    logic [7:0] main_din = 8'h00;
    logic       status_rd = 1'b0;
    logic [7:0] main_status;
    logic       snd_rd = 1'b0;
    logic [7:0] snd_latch;
    logic       snd_irq;

    int errors = 0;
    int checks = 0;

    // Model state: pending bytes, presented byte, remaining irq cycles, handshake in flight.
    logic [7:0] mq[$];
    logic [7:0] m_latch = 8'h00;
    int         m_irq_left = 0;
    bit         m_busy = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_prev_rd = 1'b0;
    int         m_wait = 0;
    bit         r_srd = 1'b0;

    jtdd2_sndcmd #(
        .DEPTH     (DEPTH),
        .IRQ_LEN   (IRQ_LEN),
        .RETRY_CYC (RETRY_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .main_wr     (main_wr),
        .main_din    (main_din),
        .status_rd   (status_rd),
        .main_status (main_status),
        .snd_rd      (snd_rd),
        .snd_latch   (snd_latch),
        .snd_irq     (snd_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit wr, input logic [7:0] din, input bit srd,
                              input bit st_rd, input bit rs);
        bit ack, pop, accept;
        if (rs) begin
            mq.delete();
            m_latch = 8'h00; m_irq_left = 0; m_busy = 0; m_ovf = 0; m_prev_rd = 0; m_wait = 0;
            return;
        end
        ack    = srd && !m_prev_rd;
        pop    = !m_busy && mq.size() != 0;
        accept = wr && (mq.size() < DEPTH || pop);
        if (wr && !accept) m_ovf = 1'b1;
        else if (st_rd)    m_ovf = 1'b0;
        if (pop) begin
            m_latch    = mq.pop_front();
            m_irq_left = IRQ_LEN;
            m_busy     = 1'b1;
        end else if (m_busy) begin
            if (ack) begin
                m_busy = 1'b0; m_irq_left = 0;
            end else if (m_irq_left > 0) begin
                m_irq_left--; m_wait = 0;
            end else begin
                m_wait++;
                if (RETRY && m_wait == RETRY_CYC) m_irq_left = IRQ_LEN;
            end
        end
        if (accept) mq.push_back(din);
        m_prev_rd = srd;
    endtask

    function automatic logic [7:0] m_status();
        return {m_busy, (mq.size() == DEPTH), m_ovf, 1'b0, 4'(mq.size())};
    endfunction

    task automatic step(input bit wr, input logic [7:0] din, input bit srd,
                        input bit st_rd, input bit rs);
        logic [7:0] exp_irq;
        main_wr = wr; main_din = din; snd_rd = srd; status_rd = st_rd; rst = rs;
        @(posedge clk);
        model_edge(wr, din, srd, st_rd, rs);
        #1;
        exp_irq = {7'b0, (m_irq_left > 0)};
        chk("latch", snd_latch, m_latch);
        chk("irq", {7'b0, snd_irq}, exp_irq);
        chk("status", main_status, m_status());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
    endtask

    task automatic ack();
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("rst_latch", snd_latch, 8'h00);
        chk("rst_irq", {7'b0, snd_irq}, 8'h00);
        chk("rst_status", main_status, 8'h00);

        // Single command: one-cycle latency, 16-cycle irq pulse
        step(1, 8'h5A, 0, 0, 0);
        idle(1);
        chk("first_latch", snd_latch, 8'h5A);
        chk("first_irq", {7'b0, snd_irq}, 8'h01);
        idle(15);
        chk("irq_last_cycle", {7'b0, snd_irq}, 8'h01);
        idle(1);
        chk("irq_end", {7'b0, snd_irq}, 8'h00);
        chk("wait_status", main_status, 8'h80);
        ack();
        chk("idle_status", main_status, 8'h00);

        // Back-to-back commands; long snd_rd level advances only once
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        idle(1);
        chk("b2b_latch", snd_latch, 8'h01);
        chk("b2b_status", main_status, 8'h82);
        idle(20);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 1, 0, 0);
            if (i == 1) chk("adv_latch", snd_latch, 8'h02);
        end
        chk("one_adv", snd_latch, 8'h02);
        step(0, 8'h00, 0, 0, 0);
        idle(20);
        ack();
        chk("adv2_latch", snd_latch, 8'h03);
        idle(20);
        ack();
        chk("drain_status", main_status, 8'h00);

        // Overflow: fill beyond depth, sticky ovf cleared by status read
        for (int i = 0; i < 7; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
        chk("ovf_status", main_status, 8'hE4);
        chk("ovf_latch", snd_latch, 8'hA0);
        step(0, 8'h00, 0, 1, 0);
        chk("ovf_clear", main_status, 8'hC4);
        ack();
        // Ack on the third pulse cycle of A1
        idle(2);
        step(0, 8'h00, 1, 0, 0);
        chk("pulse_ack_irq", {7'b0, snd_irq}, 8'h00);
        step(0, 8'h00, 0, 0, 0);
        chk("pulse_ack_next", snd_latch, 8'hA2);
        for (int i = 0; i < 3; i++) begin
            idle(20);
            ack();
        end
        idle(2);
        chk("ovf_drain", main_status, 8'h00);

        // Reset in WAIT_ACK with three queued
        for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), 0, 0, 0);
        idle(20);
        step(0, 8'h00, 0, 0, 1);
        chk("mid_rst_irq", {7'b0, snd_irq}, 8'h00);
        chk("mid_rst_latch", snd_latch, 8'h00);
        chk("mid_rst_status", main_status, 8'h00);
        ack();
        idle(2);
        chk("post_rst_status", main_status, 8'h00);

        // Unacknowledged command: re-pulse only in the retry build
        step(1, 8'hC3, 0, 0, 0);
        idle(17);
        chk("retry_gap_start", {7'b0, snd_irq}, 8'h00);
        idle(99);
        chk("retry_gap_end", {7'b0, snd_irq}, 8'h00);
        idle(1);
        chk("retry_irq", {7'b0, snd_irq}, {7'b0, RETRY});
        chk("retry_latch", snd_latch, 8'hC3);
        idle(50);
        ack();
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r_srd = ~r_srd;
            step(($urandom_range(0, 3) == 0), 8'($urandom), r_srd,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtdd2_sndcmd.md
Name: jtdd2_sndcmd

Overview:
- Main-CPU-side sound command channel.
- Buffers command bytes written by the main CPU in a small FIFO.
- Presents one byte at a time on snd_latch and raises snd_irq to the sound subsystem.
- Waits for the sound CPU to read the latch (latch_cs acknowledge) before presenting the next byte, so back-to-back commands are never lost.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, 2..8.
- IRQ_LEN, 16, snd_irq high time in clk cycles, 1..255.
- RETRY_CYC, 4096, cycles in WAIT_ACK before an irq re-pulse; used only with JTDD2_SNDCMD_RETRY_EN.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  reset, synchronous, active-high.
- main_wr  in  1  one-cycle command write strobe from main CPU decode.
- main_din  in  8  command byte, valid with main_wr.
- status_rd  in  1  one-cycle strobe; main CPU reads status this cycle.
- main_status  out  8  {busy, full, ovf, 1'b0, count[3:0]}.
- snd_rd  in  1  sound-side latch_cs (level, may last many cycles).
- snd_latch  out  8  byte presented to sound CPU.
- snd_irq  out  1  command-pending pulse to sound-side edge flip-flop.

Behaviour:
- Reset:
  - FIFO empty; count=0; ovf=0; busy=0.
  - snd_latch=8'h00; snd_irq=0; state IDLE.
  - Reset mid-transfer discards all queued bytes and drops snd_irq in the same cycle.
- FIFO: circular, wr/rd pointers log2(DEPTH) bits; count 0..DEPTH; full = (count==DEPTH).
- Writes:
  - main_wr while not full: store byte, wr pointer +1.
  - main_wr while full: byte dropped, ovf set (sticky).
  - ovf is cleared on status_rd. If status_rd and a dropped write coincide, ovf stays set.
- Ack detect: register snd_rd; ack = snd_rd & ~snd_rd_q. Only the rising edge counts.
- State machine:
  - IDLE: if count!=0, pop head into snd_latch, set snd_irq=1, load irq counter with IRQ_LEN, go to PULSE.
  - PULSE: decrement irq counter. At 1, clear snd_irq and go to WAIT_ACK. An ack during PULSE clears snd_irq at once and goes to IDLE.
  - WAIT_ACK: on ack go to IDLE. snd_latch holds its value until the next pop.
- busy = (state!=IDLE).
- Latency:
  - main_wr sampled at edge k, FIFO previously empty and IDLE → snd_latch and snd_irq change at edge k+1.
  - After an ack at edge j, the next queued byte appears at edge j+1.
- Simultaneous write and pop in the same cycle: both happen; count unchanged; a write to a full FIFO during a pop is accepted.
- snd_latch never changes while state is PULSE or WAIT_ACK.
- count is reported zero-extended to 4 bits.

Optional Feature:
- JTDD2_SNDCMD_RETRY_EN defined:
  - WAIT_ACK counts cycles. Reaching RETRY_CYC with no ack re-enters PULSE with the same snd_latch, so snd_irq re-pulses for IRQ_LEN cycles.
  - The counter clears on entering WAIT_ACK.
- Not defined: WAIT_ACK waits forever; retry counter and RETRY_CYC logic are absent.

Test Plan:
- Reset then main_wr din=8'h5A → snd_latch=8'h5A and snd_irq=1 one clk later. snd_irq stays high 16 clks, then 0. main_status=8'h80.
- Write 8'h01, 8'h02, 8'h03 on consecutive clks → latch=8'h01, count reads 2. Assert snd_rd for 5 clks → latch=8'h02 one clk after the rising edge, and only one advance occurs. Repeat the ack → 8'h03, then IDLE with status=8'h00.
- Fill DEPTH=4 (latch holds the 1st byte, 4 queued), then 2 more writes → full=1, ovf=1, extra bytes never appear. status_rd → ovf=0 next clk.
- Ack during PULSE at clk 3 → snd_irq=0 next clk; the next byte is presented one clk after that.
- rst asserted while in WAIT_ACK with 3 queued → next clk: snd_irq=0, snd_latch=8'h00, status=8'h00. A later ack is ignored.
- With JTDD2_SNDCMD_RETRY_EN and RETRY_CYC=100: write 8'hC3, no ack → snd_irq re-pulses 100 clks after the first pulse ends, snd_latch still 8'hC3. Without the macro → no second pulse.
